// File: rtl/pipe_stall_ctrl_if.sv
// Stall/flush handshake bundle between the pipeline stages and pipe_stall_ctrl.
// The stall_cnt_o field exists only when STALL_PERF_CNT_EN is defined.
interface pipe_stall_ctrl_if #(
  parameter int CNT_W   = 6,
  parameter int STALL_W = 6
);
  logic               stallreq_id_i;
  logic               stallreq_ex_i;
  logic               mc_start_i;
  logic [CNT_W-1:0]   mc_cycles_i;
  logic               flush_i;
  logic [STALL_W-1:0] stall_o;
  logic               flush_o;
  logic               mc_busy_o;
  logic               mc_done_o;
  logic [CNT_W-1:0]   mc_remain_o;
`ifdef STALL_PERF_CNT_EN
  logic [31:0]        stall_cnt_o;
`endif

  // Pipeline side: raises requests, consumes the stall vector.
  modport master (
`ifdef STALL_PERF_CNT_EN
    input  stall_cnt_o,
`endif
    output stallreq_id_i, stallreq_ex_i, mc_start_i, mc_cycles_i, flush_i,
    input  stall_o, flush_o, mc_busy_o, mc_done_o, mc_remain_o
  );

  // Controller side.
  modport slave (
`ifdef STALL_PERF_CNT_EN
    output stall_cnt_o,
`endif
    input  stallreq_id_i, stallreq_ex_i, mc_start_i, mc_cycles_i, flush_i,
    output stall_o, flush_o, mc_busy_o, mc_done_o, mc_remain_o
  );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// Central stall/flush sequencer for the 5-stage core, including the multi-cycle
// execute sequencer. Define STALL_PERF_CNT_EN to add the saturating stall counter.
module pipe_stall_ctrl #(
  parameter int CNT_W   = 6,
  parameter int STALL_W = 6
) (
  input logic              clk,
  input logic              rst,
  pipe_stall_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Stall masks: bit 0 pc, 1 if, 2 id, 3 ex, 4 mem, 5 wb.
  localparam logic [STALL_W-1:0] STALL_EX = STALL_W'(4'b1111);
  localparam logic [STALL_W-1:0] STALL_ID = STALL_W'(3'b111);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   neff;
  logic               mc_stall;
  logic [STALL_W-1:0] stall_raw;

  always_comb begin
    neff = (bus.mc_cycles_i == '0) ? CNT_W'(1) : bus.mc_cycles_i;
  end

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    mc_stall = 1'b0;
    unique case (state)
      IDLE:    mc_stall = bus.mc_start_i & ~bus.flush_i;
      BUSY:    mc_stall = 1'b1;
      default: mc_stall = 1'b0;
    endcase
  end

  always_comb begin
    stall_raw = '0;
    if (bus.flush_i)                        stall_raw = '0;
    else if (mc_stall || bus.stallreq_ex_i) stall_raw = STALL_EX;
    else if (bus.stallreq_id_i)             stall_raw = STALL_ID;
  end

  // Combinational outputs are forced low while reset is held so the pipeline
  // registers never see a stall or flush from an undefined request.
  assign bus.stall_o     = rst ? stall_raw : '0;
  assign bus.flush_o     = rst & bus.flush_i;
  assign bus.mc_busy_o   = rst & mc_stall;
  assign bus.mc_done_o   = rst & (state == DONE) & ~bus.flush_i;
  assign bus.mc_remain_o = (rst && state == BUSY) ? cnt : '0;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (bus.flush_i) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.mc_start_i) begin
            if (neff == CNT_W'(1)) begin
              state <= DONE;
              cnt   <= '0;
            end else begin
              state <= BUSY;
              cnt   <= neff - CNT_W'(1);
            end
          end
        end
        BUSY: begin
          // Exit at 1 so the count never wraps through zero.
          if (cnt == CNT_W'(1)) begin
            state <= DONE;
            cnt   <= '0;
          end else begin
            cnt   <= cnt - CNT_W'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          cnt   <= '0;
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

`ifdef STALL_PERF_CNT_EN
  logic [31:0] perf_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_cnt <= '0;
    end else if (bus.stall_o[0] && perf_cnt != 32'hFFFF_FFFF) begin
      perf_cnt <= perf_cnt + 32'd1;
    end
  end

  assign bus.stall_cnt_o = perf_cnt;
`endif

  a_done_single: assert property (@(posedge clk) disable iff (!rst)
    bus.mc_done_o |=> !bus.mc_done_o);

  a_busy_count_nonzero: assert property (@(posedge clk) disable iff (!rst)
    (state == BUSY) |-> (cnt != '0));

endmodule
